seg_decode: RTL and testbench
=============================

SEG_DECODE -- requirements
Module: seg_decode

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, legal range 1..255, the number of consecutive identical samples required to accept a pattern.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port i_seg, input, 8, active-low segment lines: bit7=a ... bit1=g, bit0=dp.
REQ-005 SHALL have port i_ready, input, 1, consumer accepts the pending digit.
REQ-006 SHALL have port o_valid, output, 1, a decoded digit is pending.
REQ-007 SHALL have port o_digit, output, 4, decoded value.
REQ-008 SHALL have port o_dp, output, 1, decimal point state (active-high) of the accepted pattern.
REQ-009 SHALL have port o_err, output, 1, one-cycle pulse when an unrecognised pattern is accepted.
REQ-010 SHALL have port o_err_cnt, output, 8, saturating count of o_err pulses.
REQ-011 SHALL have port o_ovf, output, 1, sticky flag: a pending digit was overwritten.

Function
REQ-012 SHALL register i_seg every edge into s_reg; decoding uses pat = ~s_reg.
REQ-013 SHALL match pat[7:1] only: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-014 SHALL keep stable_cnt: reload to 1 when the new s_reg differs from the old one, otherwise increment, saturating at STABLE_CYCLES.
REQ-015 SHALL accept a pattern on the edge at which stable_cnt becomes STABLE_CYCLES, and only if s_reg differs from last_acc.
REQ-016 SHALL set last_acc to s_reg on every acceptance.
REQ-017 Timing: with i_seg=P applied before edge e0 and held, o_valid/o_err SHALL be visible after edge e0+STABLE_CYCLES-1.
REQ-018 A held pattern SHALL be reported once; it is reported again only after a different pattern has been accepted in between.
REQ-019 A blank pattern (pat[7:1]=0) SHALL update last_acc and produce neither o_valid nor o_err.
REQ-020 On accepting a recognised pattern, SHALL load o_digit and o_dp and set o_valid.
REQ-021 On accepting an unrecognised non-blank pattern, SHALL pulse o_err for 1 cycle and increment o_err_cnt, saturating at 255.
REQ-022 FSM IDLE->HOLD on a valid acceptance.
REQ-023 FSM HOLD->IDLE when o_valid&&i_ready.
REQ-024 FSM HOLD->HOLD on a simultaneous handshake and new valid acceptance: data is replaced, o_ovf is not set.
REQ-025 In HOLD without i_ready, a new valid acceptance SHALL replace o_digit/o_dp and set o_ovf.
REQ-026 In HOLD, an error acceptance SHALL leave the pending data and o_valid unchanged.
REQ-027 While o_valid=1 and i_ready=0, o_digit and o_dp SHALL be stable except per REQ-025.

Reset
REQ-028 While rst_n=0 at an edge, SHALL clear o_valid, o_digit, o_dp, o_err, o_err_cnt, o_ovf and stable_cnt, set s_reg=last_acc=8'hFF, and set state=IDLE.
REQ-029 Reset mid-pattern SHALL discard partial stability; counting restarts from the first post-reset edge.

Configuration
REQ-030 Macro SEG_DECODE_HEX_EN defined: SHALL also decode A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111 to 10..15.
REQ-031 Macro SEG_DECODE_HEX_EN undefined: those patterns SHALL be treated as errors.

Structure
REQ-032 Package seg_pkg SHALL hold the ten (plus six hex) 7-bit pattern constants, the FSM state enum, and the STABLE_CYCLES default.
REQ-033 Combinational sub-module seg_pat_lut SHALL map pat[7:1] to {hit, blank, value[3:0]}.

Verification
REQ-034 rst_n=0 for 2 edges with i_seg=8'h02 -> all outputs 0; then hold 8'h02 for 4 edges -> o_valid=1, o_digit=0, o_dp=1.
REQ-035 Hold 8'h0D with i_ready=0 -> o_digit=3 stays pending; i_ready=1 for 1 cycle -> o_valid=0 next cycle, no re-report while 8'h0D is held.
REQ-036 8'h9F for 3 edges, then 8'h0D held -> no event for 9F; digit 3 reported after 4 edges.
REQ-037 Alternate 8'h7F/8'hFF/8'h7F... each held 4 edges -> one o_err pulse per 7F; after 300 such events o_err_cnt=255.
REQ-038 Digit 1 (8'h9F) pending with i_ready=0, then 8'h00 held 4 edges -> o_digit=8, o_ovf=1.
REQ-039 8'h11 held 4 edges -> o_digit=10 with SEG_DECODE_HEX_EN; o_err pulse and o_err_cnt+1 without it.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment decoder: segment patterns
// (pat[7:1] order a..g), FSM state encoding and the default debounce depth.
// The hex patterns are only consulted when SEG_DECODE_HEX_EN is defined.
package seg_pkg;

  localparam int STABLE_CYCLES_DEF = 4;

  localparam logic [6:0] PAT_0 = 7'b1111110;
  localparam logic [6:0] PAT_1 = 7'b0110000;
  localparam logic [6:0] PAT_2 = 7'b1101101;
  localparam logic [6:0] PAT_3 = 7'b1111001;
  localparam logic [6:0] PAT_4 = 7'b0110011;
  localparam logic [6:0] PAT_5 = 7'b1011011;
  localparam logic [6:0] PAT_6 = 7'b1011111;
  localparam logic [6:0] PAT_7 = 7'b1110000;
  localparam logic [6:0] PAT_8 = 7'b1111111;
  localparam logic [6:0] PAT_9 = 7'b1111011;

  localparam logic [6:0] PAT_A = 7'b1110111;
  localparam logic [6:0] PAT_B = 7'b0011111;
  localparam logic [6:0] PAT_C = 7'b1001110;
  localparam logic [6:0] PAT_D = 7'b0111101;
  localparam logic [6:0] PAT_E = 7'b1001111;
  localparam logic [6:0] PAT_F = 7'b1000111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } seg_state_e;

endpackage

// File: rtl/seg_pat_lut.sv
// Combinational segment-pattern lookup: active-high a..g -> {hit, blank, value}.
// Define SEG_DECODE_HEX_EN to also recognise A..F (values 10..15).
module seg_pat_lut
  import seg_pkg::*;
(
  input  logic [6:0] pat7,
  output logic       hit,
  output logic       blank,
  output logic [3:0] value
);

  // Map the lit segments to a digit; anything unlisted is a miss.
  always_comb begin
    hit   = 1'b1;
    blank = 1'b0;
    value = 4'd0;
    case (pat7)
      PAT_0: value = 4'd0;
      PAT_1: value = 4'd1;
      PAT_2: value = 4'd2;
      PAT_3: value = 4'd3;
      PAT_4: value = 4'd4;
      PAT_5: value = 4'd5;
      PAT_6: value = 4'd6;
      PAT_7: value = 4'd7;
      PAT_8: value = 4'd8;
      PAT_9: value = 4'd9;
`ifdef SEG_DECODE_HEX_EN
      PAT_A: value = 4'd10;
      PAT_B: value = 4'd11;
      PAT_C: value = 4'd12;
      PAT_D: value = 4'd13;
      PAT_E: value = 4'd14;
      PAT_F: value = 4'd15;
`endif
      7'b0000000: begin
        hit   = 1'b0;
        blank = 1'b1;
      end
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_decode.sv
// Debounced seven-segment pattern decoder with a one-deep valid/ready output.
// A pattern must be seen STABLE_CYCLES consecutive samples and differ from
// the last accepted pattern before it is reported. Hex digits A..F are
// decoded only when SEG_DECODE_HEX_EN is defined; otherwise they are errors.
//
// state   | meaning
// IDLE    | no digit pending, o_valid = 0
// HOLD    | digit pending in o_digit/o_dp, waiting for i_ready
module seg_decode
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_seg,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [3:0] o_digit,
  output logic       o_dp,
  output logic       o_err,
  output logic [7:0] o_err_cnt,
  output logic       o_ovf
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [7:0] s_reg;
  logic [7:0] last_acc;
  logic [7:0] stable_cnt;
  logic [7:0] cnt_nxt;
  logic       accept;
  logic       hit;
  logic       blank;
  logic [3:0] value;
  logic       acc_valid;
  logic       acc_err;

  seg_state_e state, state_nxt;
  logic [3:0] digit_nxt;
  logic       dp_nxt;
  logic       ovf_nxt;

  // Decode the sample being registered this edge so acceptance lands on
  // the same edge that completes the stability run.
  seg_pat_lut u_lut (
    .pat7  (~i_seg[7:1]),
    .hit   (hit),
    .blank (blank),
    .value (value)
  );

  // Stability run length and the "becomes STABLE_CYCLES" acceptance test.
  always_comb begin
    cnt_nxt = stable_cnt;
    if (i_seg != s_reg) begin
      cnt_nxt = 8'd1;
    end else if (stable_cnt < STABLE_MAX) begin
      cnt_nxt = stable_cnt + 8'd1;
    end
    accept    = (cnt_nxt == STABLE_MAX) &&
                ((stable_cnt != STABLE_MAX) || (i_seg != s_reg)) &&
                (i_seg != last_acc);
    acc_valid = accept && hit;
    acc_err   = accept && !hit && !blank;
  end

  // Sample register, run counter and last-accepted pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_reg      <= 8'hFF;
      last_acc   <= 8'hFF;
      stable_cnt <= 8'd0;
    end else begin
      s_reg      <= i_seg;
      stable_cnt <= cnt_nxt;
      if (accept) begin
        last_acc <= i_seg;
      end
    end
  end

  // Next-state and pending-data logic; a new digit always wins over the old.
  always_comb begin
    state_nxt = state;
    digit_nxt = o_digit;
    dp_nxt    = o_dp;
    ovf_nxt   = o_ovf;
    case (state)
      ST_IDLE: begin
        if (acc_valid) begin
          state_nxt = ST_HOLD;
          digit_nxt = value;
          dp_nxt    = ~i_seg[0];
        end
      end
      ST_HOLD: begin
        if (acc_valid) begin
          digit_nxt = value;
          dp_nxt    = ~i_seg[0];
          if (!i_ready) begin
            ovf_nxt = 1'b1;
          end
        end else if (i_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and pending digit registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      o_digit <= 4'd0;
      o_dp    <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_digit <= digit_nxt;
      o_dp    <= dp_nxt;
      o_ovf   <= ovf_nxt;
    end
  end

  // Error pulse and saturating error counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_err     <= 1'b0;
      o_err_cnt <= 8'd0;
    end else begin
      o_err <= acc_err;
      if (acc_err && (o_err_cnt != 8'hFF)) begin
        o_err_cnt <= o_err_cnt + 8'd1;
      end
    end
  end

  assign o_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_seg_decode.sv
// Bench for seg_decode: directed scenarios plus randomized patterns, all
// checked every cycle against a run-length based reference model.
module tb_seg_decode;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_seg = 8'hFF;
  logic       i_ready = 1'b0;
  logic       o_valid;
  logic [3:0] o_digit;
  logic       o_dp;
  logic       o_err;
  logic [7:0] o_err_cnt;
  logic       o_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [7:0] m_prev, m_last;
  int m_run, m_digit, m_errcnt;
  bit m_valid, m_dp, m_err, m_ovf;
  logic [6:0] pat_tab [16];

  seg_decode #(.STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_seg     (i_seg),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_digit   (o_digit),
    .o_dp      (o_dp),
    .o_err     (o_err),
    .o_err_cnt (o_err_cnt),
    .o_ovf     (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit lookup(input logic [6:0] p, output int val);
    int n_sym;
`ifdef SEG_DECODE_HEX_EN
    n_sym = 16;
`else
    n_sym = 10;
`endif
    val = 0;
    for (int k = 0; k < n_sym; k++) begin
      if (pat_tab[k] == p) begin
        val = k;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_edge(input logic [7:0] seg, input logic rdy, input logic rst);
    logic [7:0] pat;
    int v;
    bit found;
    m_err = 1'b0;
    if (!rst) begin
      m_prev = 8'hFF; m_last = 8'hFF; m_run = 0;
      m_valid = 0; m_digit = 0; m_dp = 0; m_ovf = 0; m_errcnt = 0;
      return;
    end
    m_run = (seg != m_prev) ? 1 : m_run + 1;
    m_prev = seg;
    pat = ~seg;
    found = lookup(pat[7:1], v);
    if (m_run == S && seg != m_last) begin
      m_last = seg;
      if (pat[7:1] == 7'd0) begin
        if (m_valid && rdy) m_valid = 0;
      end else if (found) begin
        if (m_valid && !rdy) m_ovf = 1;
        m_valid = 1; m_digit = v; m_dp = pat[0];
      end else begin
        m_err = 1;
        if (m_errcnt < 255) m_errcnt++;
        if (m_valid && rdy) m_valid = 0;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input logic [7:0] seg, input logic rdy, input logic rst);
    i_seg = seg; i_ready = rdy; rst_n = rst;
    @(posedge clk);
    model_edge(seg, rdy, rst);
    #1;
    check_val("valid", 32'(o_valid), 32'(m_valid));
    check_val("err", 32'(o_err), 32'(m_err));
    check_val("err_cnt", 32'(o_err_cnt), 32'(m_errcnt));
    check_val("ovf", 32'(o_ovf), 32'(m_ovf));
    if (m_valid) begin
      check_val("digit", 32'(o_digit), 32'(m_digit));
      check_val("dp", 32'(o_dp), 32'(m_dp));
    end
  endtask

  task automatic hold(input logic [7:0] seg, input logic rdy, input int n);
    repeat (n) step(seg, rdy, 1'b1);
  endtask

  logic [7:0] pool [12];

  initial begin
    pat_tab[0] = 7'b1111110; pat_tab[1] = 7'b0110000; pat_tab[2] = 7'b1101101;
    pat_tab[3] = 7'b1111001; pat_tab[4] = 7'b0110011; pat_tab[5] = 7'b1011011;
    pat_tab[6] = 7'b1011111; pat_tab[7] = 7'b1110000; pat_tab[8] = 7'b1111111;
    pat_tab[9] = 7'b1111011; pat_tab[10] = 7'b1110111; pat_tab[11] = 7'b0011111;
    pat_tab[12] = 7'b1001110; pat_tab[13] = 7'b0111101; pat_tab[14] = 7'b1001111;
    pat_tab[15] = 7'b1000111;
    pool = '{8'h02, 8'h9F, 8'h0D, 8'h00, 8'h11, 8'hFF, 8'h7F, 8'hFE, 8'h03, 8'h25, 8'hC1, 8'h83};

    // reset with digit 0 + dp presented, then accept it after S edges
    step(8'h02, 1'b0, 1'b0);
    step(8'h02, 1'b0, 1'b0);
    check_val("rst_valid", 32'(o_valid), 32'd0);
    check_val("rst_cnt", 32'(o_err_cnt), 32'd0);
    hold(8'h02, 1'b0, 3);
    check_val("d0_early", 32'(o_valid), 32'd0);
    hold(8'h02, 1'b0, 1);
    check_val("d0_valid", 32'(o_valid), 32'd1);
    check_val("d0_digit", 32'(o_digit), 32'd0);
    check_val("d0_dp", 32'(o_dp), 32'd1);

    // digit 3 stays pending, one handshake clears it, no re-report
    step(8'h0D, 1'b1, 1'b1);
    hold(8'h0D, 1'b0, 5);
    check_val("d3_digit", 32'(o_digit), 32'd3);
    check_val("d3_valid", 32'(o_valid), 32'd1);
    step(8'h0D, 1'b1, 1'b1);
    check_val("d3_ack", 32'(o_valid), 32'd0);
    hold(8'h0D, 1'b0, 6);
    check_val("d3_norep", 32'(o_valid), 32'd0);

    // blank, short 9F glitch, then 0D reported after S edges
    hold(8'hFF, 1'b1, 4);
    hold(8'h9F, 1'b0, 3);
    hold(8'h0D, 1'b0, 3);
    check_val("glitch_none", 32'(o_valid), 32'd0);
    step(8'h0D, 1'b0, 1'b1);
    check_val("after_glitch", 32'(o_digit), 32'd3);

    // overwrite of pending digit 1 by digit 8
    step(8'h0D, 1'b1, 1'b1);
    hold(8'h9F, 1'b0, 4);
    check_val("d1_digit", 32'(o_digit), 32'd1);
    check_val("d1_ovf", 32'(o_ovf), 32'd0);
    hold(8'h00, 1'b0, 4);
    check_val("d8_digit", 32'(o_digit), 32'd8);
    check_val("d8_ovf", 32'(o_ovf), 32'd1);

    // hex A: decoded or error depending on build
    hold(8'h11, 1'b1, 4);
`ifdef SEG_DECODE_HEX_EN
    check_val("hexA_digit", 32'(o_digit), 32'd10);
    check_val("hexA_valid", 32'(o_valid), 32'd1);
`else
    check_val("hexA_err", 32'(o_err), 32'd1);
    check_val("hexA_cnt", 32'(o_err_cnt), 32'd1);
`endif

    // reset in the middle of a run restarts counting
    hold(8'h02, 1'b1, 2);
    step(8'h02, 1'b1, 1'b0);
    check_val("mid_rst_ovf", 32'(o_ovf), 32'd0);
    hold(8'h02, 1'b0, 3);
    check_val("mid_rst_early", 32'(o_valid), 32'd0);
    hold(8'h02, 1'b0, 1);
    check_val("mid_rst_valid", 32'(o_valid), 32'd1);

    // 300 error events saturate the counter
    for (int i = 0; i < 300; i++) begin
      hold(8'h7F, 1'b1, 4);
      hold(8'hFF, 1'b1, 4);
    end
    check_val("err_sat", 32'(o_err_cnt), 32'd255);

    // randomized patterns, hold lengths, ready and occasional reset
    for (int i = 0; i < 400; i++) begin
      logic [7:0] seg;
      int len;
      seg = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        step(seg, ($urandom_range(0, 3) == 0), ($urandom_range(0, 60) != 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
